cd_dma_ctrl: RTL and testbench
==============================

Name: cd_dma_ctrl

Overview:
Parametrised DMA engine for the CD system block, the successor to the bare DMA register set.
- Programmed through a word-wide register port by the 68K decode logic.
- Arbitrates for the 68K bus with a BR/BG/BGACK handshake.
- Moves words source->destination (COPY) or writes a constant (FILL), then raises a completion interrupt request.
- Generalised in address width, count width and mode, with abort and a zero-count shortcut.

Parameters:
ADDR_W, 24, byte address width of source/destination (bit 0 always 0; word transfers only)
COUNT_W, 32, word-count register width
DATA_W, 16, data word width

Ports:
CLK_68KCLK  in  1  system clock
RESET  in  1  asynchronous active-high reset
REG_WR  in  1  one-cycle register write strobe
REG_SEL  in  3  register index: 0 CTRL, 1 SRC_HI, 2 SRC_LO, 3 DST_HI, 4 DST_LO, 5 VALUE, 6 COUNT_HI, 7 COUNT_LO
REG_WDATA  in  16  register write data
STATUS  out  16  bit0 BUSY, bit1 DONE, bit2 ABORTED, bit3 MODE, others 0
nBR  out  1  bus request, active low
nBG  in  1  bus grant, active low
nBGACK  out  1  bus grant acknowledge, active low
MEM_REQ  out  1  memory access request
MEM_WE  out  1  1=write, 0=read, valid with MEM_REQ
MEM_ADDR  out  ADDR_W  byte address
MEM_WDATA  out  DATA_W  write data
MEM_RDATA  in  DATA_W  read data, valid with MEM_ACK
MEM_ACK  in  1  access complete, one cycle
IRQ  out  1  level interrupt request, active high
CHECKSUM  out  16  running word sum (exists only with CD_DMA_CHECKSUM_EN)

Behaviour:
Reset values:
- nBR=1, nBGACK=1, MEM_REQ=0, MEM_WE=0, IRQ=0.
- MEM_ADDR, MEM_WDATA and all registers 0; STATUS=0.
Register fields:
- HI/LO pairs concatenate and truncate to ADDR_W / COUNT_W. Bit 0 of SRC/DST is forced to 0.
- CTRL: bit0 START, bit1 MODE (0 COPY, 1 FILL), bit2 IRQ_EN, bit3 IRQ_CLR.
Writes while BUSY:
- Writes to regs 1-7 are ignored.
- CTRL write with START=0 requests an abort.
- CTRL write with START=1 is ignored.
IRQ_CLR=1 clears DONE, ABORTED and IRQ in any state; it is self-clearing.
States:
- IDLE
  - On CTRL write with START=1: latch MODE, IRQ_EN and working copies of SRC/DST/COUNT; clear DONE and ABORTED.
  - COUNT==0: go to DONE with no bus request.
  - Otherwise: go to BUSREQ, set BUSY, nBR=0.
- BUSREQ
  - nBG sampled 0: next cycle nBGACK=0, nBR=1; COPY goes to RD, FILL goes to WR.
  - Abort here: nBR=1, go to DONE with ABORTED=1.
- RD
  - MEM_REQ=1, MEM_WE=0, MEM_ADDR=src. Hold until MEM_ACK.
  - On MEM_ACK: capture MEM_RDATA, src+=2, go to WR.
- WR
  - MEM_REQ=1, MEM_WE=1, MEM_ADDR=dst.
  - MEM_WDATA = captured word (COPY) or VALUE (FILL). Hold until MEM_ACK.
  - On MEM_ACK: dst+=2, count-=1.
  - count reaching 0 goes to DONE. Otherwise, if an abort is pending, go to DONE with ABORTED=1. Otherwise go to RD (COPY) or stay in WR (FILL).
- DONE (one cycle)
  - MEM_REQ=0, nBGACK=1, BUSY=0, DONE=1.
  - IRQ=1 if IRQ_EN. Return to IDLE.
Timing:
- MEM_REQ drops in the cycle after MEM_ACK; back-to-back accesses have at least one idle cycle between them.
- The minimum single-word FILL from START write to DONE is 4 cycles plus grant latency plus ack latency.
Arithmetic and boundaries:
- Address increments wrap modulo 2^ADDR_W.
- Abort is pending from the CTRL write until it is honoured. It is honoured only at word boundaries and never mid-access. Abort on the last word yields DONE=1 with ABORTED=0.
- IRQ_CLR in the same cycle as DONE entry: the set wins.
- RESET mid-transfer: bus released immediately (nBR=1, nBGACK=1, MEM_REQ=0).

Optional Feature:
CD_DMA_CHECKSUM_EN
- Defined: CHECKSUM port exists.
  - Cleared on START.
  - Adds each written data word modulo 2^16 on the WR-state MEM_ACK.
  - Holds its value after DONE.
  - STATUS bit4 is 1, flagging that the feature is present.
- Undefined: no CHECKSUM port, no adder, STATUS bit4=0.

Test Plan:
- COPY 3 words: SRC=0x100000, DST=0x200000, COUNT=3, memory acks after 2 cycles -> reads at 0x100000/02/04, writes at 0x200000/02/04 with the same data; DONE=1; IRQ=1 with IRQ_EN.
- FILL: VALUE=0xA5A5, DST=0xE00000, COUNT=4 -> exactly 4 writes of 0xA5A5, no reads, nBGACK released in DONE.
- COUNT=0 with START -> no nBR assertion, DONE=1 within 2 cycles, IRQ follows IRQ_EN.
- Abort: CTRL=0 written during word 2 of a COUNT=10 COPY -> word 2 completes, ABORTED=1, DONE=1, exactly 2 writes.
- Wrap: ADDR_W=24, DST=0xFFFFFE, FILL COUNT=2 -> writes at 0xFFFFFE then 0x000000.
- With CD_DMA_CHECKSUM_EN: FILL of 0x8000 x3 -> CHECKSUM=0x8000; RESET mid-transfer -> nBR=1, nBGACK=1, MEM_REQ=0 immediately.

Source files
------------

// File: rtl/cd_dma_ctrl_if.sv
// Register-port, 68K bus-arbitration and memory-access signal bundle for cd_dma_ctrl.
// The master modport is the DMA engine's view; the slave modport is the 68K decode/bus side.
interface cd_dma_ctrl_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic              REG_WR;
  logic [2:0]        REG_SEL;
  logic [15:0]       REG_WDATA;
  logic [15:0]       STATUS;
  logic              nBR;
  logic              nBG;
  logic              nBGACK;
  logic              MEM_REQ;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              MEM_ACK;
  logic              IRQ;

  modport master (
    input  REG_WR, REG_SEL, REG_WDATA, nBG, MEM_RDATA, MEM_ACK,
    output STATUS, nBR, nBGACK, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, IRQ
  );

  modport slave (
    output REG_WR, REG_SEL, REG_WDATA, nBG, MEM_RDATA, MEM_ACK,
    input  STATUS, nBR, nBGACK, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, IRQ
  );
endinterface

// File: rtl/cd_dma_ctrl.sv
// CD system-block DMA engine: word COPY/FILL over the 68K bus with BR/BG/BGACK arbitration.
// Optional running write checksum enabled by defining CD_DMA_CHECKSUM_EN.
module cd_dma_ctrl #(
  parameter int ADDR_W  = 24,
  parameter int COUNT_W = 32,
  parameter int DATA_W  = 16
) (
  input  logic              CLK_68KCLK,
  input  logic              RESET,
  cd_dma_ctrl_if.master     bus
`ifdef CD_DMA_CHECKSUM_EN
  ,
  output logic [15:0]       CHECKSUM
`endif
);

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_SRC_HI   = 3'd1,
    REG_SRC_LO   = 3'd2,
    REG_DST_HI   = 3'd3,
    REG_DST_LO   = 3'd4,
    REG_VALUE    = 3'd5,
    REG_COUNT_HI = 3'd6,
    REG_COUNT_LO = 3'd7
  } reg_sel_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSREQ,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

`ifdef CD_DMA_CHECKSUM_EN
  localparam logic CSUM_PRESENT = 1'b1;
`else
  localparam logic CSUM_PRESENT = 1'b0;
`endif

  state_t              state_q, state_d;

  // Programmed registers
  logic [ADDR_W-1:0]   src_cfg, dst_cfg;
  logic [COUNT_W-1:0]  cnt_cfg;
  logic [DATA_W-1:0]   value_cfg;

  // Working copies and transfer state
  logic [ADDR_W-1:0]   src_q, dst_q;
  logic [COUNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                mode_q, irq_en_q;
  logic                done_q, aborted_q, irq_q;
  logic                abort_pend_q;
  logic                gap_q;

  logic                ctrl_wr, busy, start, abort_wr, abort_now, irq_clr;
  logic                in_access, mem_req, ack_ok, last_word, irq_en_eff;
  logic                enter_done, abort_done;

  assign ctrl_wr    = bus.REG_WR && (bus.REG_SEL == REG_CTRL);
  assign busy       = (state_q == S_BUSREQ) || (state_q == S_RD) || (state_q == S_WR);
  assign start      = ctrl_wr && bus.REG_WDATA[0] && (state_q == S_IDLE);
  assign abort_wr   = ctrl_wr && !bus.REG_WDATA[0] && busy;
  assign abort_now  = abort_pend_q || abort_wr;
  assign irq_clr    = ctrl_wr && bus.REG_WDATA[3];
  assign in_access  = (state_q == S_RD) || (state_q == S_WR);
  // gap_q forces one idle cycle after every acknowledged access.
  assign mem_req    = in_access && !gap_q;
  assign ack_ok     = mem_req && bus.MEM_ACK;
  assign last_word  = (cnt_q == COUNT_W'(1));
  assign irq_en_eff = (state_q == S_IDLE) ? bus.REG_WDATA[2] : irq_en_q;

  always_ff @(posedge CLK_68KCLK or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    abort_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (cnt_cfg == '0) ? S_DONE : S_BUSREQ;
      end
      S_BUSREQ: begin
        if (abort_now) begin
          state_d    = S_DONE;
          abort_done = 1'b1;
        end else if (!bus.nBG) begin
          state_d = mode_q ? S_WR : S_RD;
        end
      end
      S_RD: begin
        if (ack_ok) state_d = S_WR;
      end
      S_WR: begin
        if (ack_ok) begin
          if (last_word) begin
            state_d = S_DONE;
          end else if (abort_now) begin
            state_d    = S_DONE;
            abort_done = 1'b1;
          end else if (!mode_q) begin
            state_d = S_RD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_done = (state_d == S_DONE);

  // Register file: writes to address/count/value are ignored while a transfer owns them.
  always_ff @(posedge CLK_68KCLK or posedge RESET) begin
    if (RESET) begin
      src_cfg   <= '0;
      dst_cfg   <= '0;
      cnt_cfg   <= '0;
      value_cfg <= '0;
    end else if (bus.REG_WR && !busy) begin
      case (reg_sel_t'(bus.REG_SEL))
        REG_SRC_HI:   src_cfg   <= ADDR_W'({bus.REG_WDATA, 16'(src_cfg)}) & ~ADDR_W'(1);
        REG_SRC_LO:   src_cfg   <= ADDR_W'({16'(src_cfg >> 16), bus.REG_WDATA[15:1], 1'b0});
        REG_DST_HI:   dst_cfg   <= ADDR_W'({bus.REG_WDATA, 16'(dst_cfg)}) & ~ADDR_W'(1);
        REG_DST_LO:   dst_cfg   <= ADDR_W'({16'(dst_cfg >> 16), bus.REG_WDATA[15:1], 1'b0});
        REG_VALUE:    value_cfg <= DATA_W'(bus.REG_WDATA);
        REG_COUNT_HI: cnt_cfg   <= COUNT_W'({bus.REG_WDATA, 16'(cnt_cfg)});
        REG_COUNT_LO: cnt_cfg   <= COUNT_W'({16'(cnt_cfg >> 16), bus.REG_WDATA});
        default: ;
      endcase
    end
  end

  // Working pointers advance only on acknowledged accesses; additions wrap at ADDR_W.
  always_ff @(posedge CLK_68KCLK or posedge RESET) begin
    if (RESET) begin
      src_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      mode_q   <= 1'b0;
      irq_en_q <= 1'b0;
      gap_q    <= 1'b0;
    end else begin
      gap_q <= ack_ok;
      if (start) begin
        src_q    <= src_cfg;
        dst_q    <= dst_cfg;
        cnt_q    <= cnt_cfg;
        mode_q   <= bus.REG_WDATA[1];
        irq_en_q <= bus.REG_WDATA[2];
      end else if (ack_ok && (state_q == S_RD)) begin
        rdata_q <= bus.MEM_RDATA;
        src_q   <= src_q + ADDR_W'(2);
      end else if (ack_ok && (state_q == S_WR)) begin
        dst_q <= dst_q + ADDR_W'(2);
        cnt_q <= cnt_q - COUNT_W'(1);
      end
    end
  end

  // Status flags: a DONE entry in the same cycle as IRQ_CLR wins because it is assigned last.
  always_ff @(posedge CLK_68KCLK or posedge RESET) begin
    if (RESET) begin
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      irq_q        <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      if (start || (state_q == S_DONE)) abort_pend_q <= 1'b0;
      else if (abort_wr)                abort_pend_q <= 1'b1;

      if (start) begin
        done_q    <= 1'b0;
        aborted_q <= 1'b0;
      end
      if (irq_clr) begin
        done_q    <= 1'b0;
        aborted_q <= 1'b0;
        irq_q     <= 1'b0;
      end
      if (enter_done) begin
        done_q <= 1'b1;
        if (abort_done) aborted_q <= 1'b1;
        if (irq_en_eff) irq_q     <= 1'b1;
      end
    end
  end

`ifdef CD_DMA_CHECKSUM_EN
  logic [15:0] csum_q;

  always_ff @(posedge CLK_68KCLK or posedge RESET) begin
    if (RESET)                            csum_q <= '0;
    else if (start)                       csum_q <= '0;
    else if (ack_ok && (state_q == S_WR)) csum_q <= csum_q + 16'(bus.MEM_WDATA);
  end

  assign CHECKSUM = csum_q;
`endif

  // Bus outputs decode from state, so an asynchronous reset releases the bus immediately.
  assign bus.nBR       = (state_q != S_BUSREQ);
  assign bus.nBGACK    = !in_access;
  assign bus.MEM_REQ   = mem_req;
  assign bus.MEM_WE    = (state_q == S_WR);
  assign bus.MEM_ADDR  = (state_q == S_RD) ? src_q :
                         (state_q == S_WR) ? dst_q : '0;
  assign bus.MEM_WDATA = (state_q != S_WR) ? '0 :
                         mode_q            ? value_cfg : rdata_q;
  assign bus.STATUS    = {11'd0, CSUM_PRESENT, mode_q, aborted_q, done_q, busy};
  assign bus.IRQ       = irq_q;

endmodule

// File: tb/tb_cd_dma_ctrl.sv
// Directed bench for cd_dma_ctrl: bus-grant and memory responders plus per-feature test tasks.
// Checksum test is compiled in when CD_DMA_CHECKSUM_EN is defined.
module tb_cd_dma_ctrl;

  logic clk;
  logic rst;

  int vectors;
  int miscompares;

  cd_dma_ctrl_if #(.ADDR_W(24), .DATA_W(16)) bus ();

`ifdef CD_DMA_CHECKSUM_EN
  logic [15:0] checksum;
  localparam logic [15:0] STATUS_RST = 16'h0010;
`else
  localparam logic [15:0] STATUS_RST = 16'h0000;
`endif

  cd_dma_ctrl #(.ADDR_W(24), .COUNT_W(32), .DATA_W(16)) dut (
    .CLK_68KCLK (clk),
    .RESET      (rst),
    .bus        (bus.master)
`ifdef CD_DMA_CHECKSUM_EN
    ,
    .CHECKSUM   (checksum)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Access log filled by the memory responder
  logic [23:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [23:0] rd_addr_q[$];
  int          br_cycles;
  logic        grant_en;
  int          lat;

  // Bus arbiter: grants one half-cycle after the request when enabled
  initial begin
    bus.nBG = 1'b1;
    forever begin
      @(negedge clk);
      bus.nBG = grant_en ? bus.nBR : 1'b1;
    end
  end

  // Memory: acknowledges each request after two cycles with a one-cycle MEM_ACK
  initial begin
    bus.MEM_ACK   = 1'b0;
    bus.MEM_RDATA = 16'h0000;
    lat = 0;
    forever begin
      @(negedge clk);
      if (bus.MEM_ACK) begin
        bus.MEM_ACK = 1'b0;
      end else if (bus.MEM_REQ === 1'b1) begin
        lat++;
        if (lat >= 2) begin
          lat = 0;
          bus.MEM_ACK = 1'b1;
          if (bus.MEM_WE) begin
            wr_addr_q.push_back(bus.MEM_ADDR);
            wr_data_q.push_back(bus.MEM_WDATA);
          end else begin
            bus.MEM_RDATA = bus.MEM_ADDR[15:0] ^ 16'hC3A5;
            rd_addr_q.push_back(bus.MEM_ADDR);
          end
        end
      end else begin
        lat = 0;
      end
    end
  end

  initial begin
    br_cycles = 0;
    forever begin
      @(negedge clk);
      if (bus.nBR === 1'b0) br_cycles++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic reg_write(input logic [2:0] sel, input logic [15:0] data);
    bus.REG_SEL   = sel;
    bus.REG_WDATA = data;
    bus.REG_WR    = 1'b1;
    @(negedge clk);
    bus.REG_WR    = 1'b0;
  endtask

  task automatic program_regs(input logic [23:0] src, input logic [23:0] dst,
                              input logic [31:0] cnt, input logic [15:0] val);
    reg_write(3'd1, {8'h00, src[23:16]});
    reg_write(3'd2, src[15:0]);
    reg_write(3'd3, {8'h00, dst[23:16]});
    reg_write(3'd4, dst[15:0]);
    reg_write(3'd5, val);
    reg_write(3'd6, cnt[31:16]);
    reg_write(3'd7, cnt[15:0]);
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    br_cycles = 0;
  endtask

  task automatic wait_done(input int budget, input string name, output int cycles);
    cycles = 0;
    while (bus.STATUS[1] !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    vectors++;
    if (bus.STATUS[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_done: DONE still %b after %0d cycles, need 1", name, bus.STATUS[1], budget);
    end
  endtask

  task automatic wait_count(input int target, input logic use_writes, input string name);
    int n = 0;
    while (((use_writes ? wr_addr_q.size() : rd_addr_q.size()) < target) && n < 500) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if ((use_writes ? wr_addr_q.size() : rd_addr_q.size()) < target) begin
      miscompares++;
      $display("FAIL %s_wait: saw %0d accesses, need %0d", name,
               use_writes ? wr_addr_q.size() : rd_addr_q.size(), target);
    end
  endtask

  task automatic irq_clear(input string name);
    reg_write(3'd0, 16'h0008);
    vectors++;
    if (bus.IRQ !== 1'b0 || bus.STATUS[2:1] !== 2'b00) begin
      miscompares++;
      $display("FAIL %s_irqclr: IRQ=%b DONE/ABORTED=%b, need 0 and 00", name, bus.IRQ, bus.STATUS[2:1]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.STATUS !== STATUS_RST) begin
      miscompares++;
      $display("FAIL reset_status: got %h, need %h", bus.STATUS, STATUS_RST);
    end
    vectors++;
    if ({bus.nBR, bus.nBGACK, bus.MEM_REQ, bus.MEM_WE, bus.IRQ} !== 5'b11000) begin
      miscompares++;
      $display("FAIL reset_ctrl: nBR,nBGACK,REQ,WE,IRQ=%b, need 11000",
               {bus.nBR, bus.nBGACK, bus.MEM_REQ, bus.MEM_WE, bus.IRQ});
    end
    vectors++;
    if (bus.MEM_ADDR !== 24'h0 || bus.MEM_WDATA !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_bus: addr=%h wdata=%h, need 0", bus.MEM_ADDR, bus.MEM_WDATA);
    end
  endtask

  task automatic test_copy();
    logic [23:0] exp_rd[3];
    logic [23:0] exp_wa[3];
    logic [15:0] exp_wd[3];
    int cyc;
    exp_rd = '{24'h100000, 24'h100002, 24'h100004};
    exp_wa = '{24'h200000, 24'h200002, 24'h200004};
    exp_wd = '{16'hC3A5, 16'hC3A7, 16'hC3A1};
    clear_log();
    program_regs(24'h100000, 24'h200000, 32'd3, 16'h0000);
    reg_write(3'd0, 16'h0005);
    wait_done(200, "copy", cyc);
    vectors++;
    if (bus.STATUS[3:0] !== 4'b0010 || bus.IRQ !== 1'b1) begin
      miscompares++;
      $display("FAIL copy_status: STATUS[3:0]=%b IRQ=%b, need 0010 and 1", bus.STATUS[3:0], bus.IRQ);
    end
    vectors++;
    if (rd_addr_q.size() != 3 || wr_addr_q.size() != 3) begin
      miscompares++;
      $display("FAIL copy_count: reads=%0d writes=%0d, need 3 and 3", rd_addr_q.size(), wr_addr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (rd_addr_q[i] !== exp_rd[i] || wr_addr_q[i] !== exp_wa[i] || wr_data_q[i] !== exp_wd[i]) begin
          miscompares++;
          $display("FAIL copy_word%0d: rd=%h wr=%h data=%h, need %h %h %h", i,
                   rd_addr_q[i], wr_addr_q[i], wr_data_q[i], exp_rd[i], exp_wa[i], exp_wd[i]);
        end
      end
    end
    irq_clear("copy");
  endtask

  task automatic test_fill();
    int cyc;
    clear_log();
    program_regs(24'h000000, 24'hE00000, 32'd4, 16'hA5A5);
    reg_write(3'd0, 16'h0003);
    wait_count(1, 1'b1, "fill");
    reg_write(3'd5, 16'h1234);
    wait_done(200, "fill", cyc);
    vectors++;
    if (bus.nBGACK !== 1'b1 || bus.MEM_REQ !== 1'b0 || bus.STATUS[3:0] !== 4'b1010) begin
      miscompares++;
      $display("FAIL fill_release: nBGACK=%b REQ=%b STATUS[3:0]=%b, need 1 0 1010",
               bus.nBGACK, bus.MEM_REQ, bus.STATUS[3:0]);
    end
    vectors++;
    if (bus.IRQ !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_irq: IRQ=%b with IRQ_EN off, need 0", bus.IRQ);
    end
    vectors++;
    if (rd_addr_q.size() != 0 || wr_addr_q.size() != 4) begin
      miscompares++;
      $display("FAIL fill_count: reads=%0d writes=%0d, need 0 and 4", rd_addr_q.size(), wr_addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (wr_addr_q[i] !== 24'hE00000 + 24'(2 * i) || wr_data_q[i] !== 16'hA5A5) begin
          miscompares++;
          $display("FAIL fill_word%0d: addr=%h data=%h, need %h A5A5", i,
                   wr_addr_q[i], wr_data_q[i], 24'hE00000 + 24'(2 * i));
        end
      end
    end
    irq_clear("fill");
  endtask

  task automatic test_zero_count();
    int cyc;
    clear_log();
    program_regs(24'h000000, 24'h000000, 32'd0, 16'h0000);
    reg_write(3'd0, 16'h0001);
    wait_done(4, "zero", cyc);
    vectors++;
    if (cyc > 2 || br_cycles != 0 || bus.IRQ !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_noirq: cycles=%0d nBR_low=%0d IRQ=%b, need <=2 0 0", cyc, br_cycles, bus.IRQ);
    end
    irq_clear("zero_a");
    reg_write(3'd0, 16'h0005);
    wait_done(4, "zero_irq", cyc);
    vectors++;
    if (cyc > 2 || br_cycles != 0 || bus.IRQ !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_irq: cycles=%0d nBR_low=%0d IRQ=%b, need <=2 0 1", cyc, br_cycles, bus.IRQ);
    end
    irq_clear("zero_b");
  endtask

  task automatic test_abort();
    int cyc;
    clear_log();
    program_regs(24'h100000, 24'h200000, 32'd10, 16'h0000);
    reg_write(3'd0, 16'h0001);
    wait_count(2, 1'b0, "abort");
    reg_write(3'd0, 16'h0000);
    wait_done(200, "abort", cyc);
    vectors++;
    if (bus.STATUS[2:0] !== 3'b110 || wr_addr_q.size() != 2 || rd_addr_q.size() != 2) begin
      miscompares++;
      $display("FAIL abort_mid: STATUS[2:0]=%b writes=%0d reads=%0d, need 110 2 2",
               bus.STATUS[2:0], wr_addr_q.size(), rd_addr_q.size());
    end
    irq_clear("abort");
  endtask

  task automatic test_abort_busreq();
    int cyc;
    clear_log();
    grant_en = 1'b0;
    program_regs(24'h100000, 24'h200000, 32'd5, 16'h0000);
    reg_write(3'd0, 16'h0001);
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.nBR !== 1'b0 || bus.STATUS[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL busreq_hold: nBR=%b BUSY=%b, need 0 1", bus.nBR, bus.STATUS[0]);
    end
    reg_write(3'd0, 16'h0000);
    wait_done(20, "busreq_abort", cyc);
    vectors++;
    if (bus.STATUS[2:0] !== 3'b110 || bus.nBR !== 1'b1 || wr_addr_q.size() != 0 || rd_addr_q.size() != 0) begin
      miscompares++;
      $display("FAIL busreq_abort: STATUS[2:0]=%b nBR=%b writes=%0d reads=%0d, need 110 1 0 0",
               bus.STATUS[2:0], bus.nBR, wr_addr_q.size(), rd_addr_q.size());
    end
    grant_en = 1'b1;
    irq_clear("busreq");
  endtask

  task automatic test_abort_last_word();
    int cyc;
    clear_log();
    program_regs(24'h000000, 24'h400000, 32'd2, 16'h0F0F);
    reg_write(3'd0, 16'h0003);
    wait_count(1, 1'b1, "abort_last");
    @(negedge clk);
    reg_write(3'd0, 16'h0000);
    wait_done(200, "abort_last", cyc);
    vectors++;
    if (bus.STATUS[2:1] !== 2'b01 || wr_addr_q.size() != 2) begin
      miscompares++;
      $display("FAIL abort_last: ABORTED/DONE=%b writes=%0d, need 01 2", bus.STATUS[2:1], wr_addr_q.size());
    end
    irq_clear("abort_last");
  endtask

  task automatic test_wrap();
    int cyc;
    clear_log();
    program_regs(24'h000000, 24'hFFFFFE, 32'd2, 16'h5A5A);
    reg_write(3'd0, 16'h0003);
    wait_done(200, "wrap", cyc);
    vectors++;
    if (wr_addr_q.size() != 2) begin
      miscompares++;
      $display("FAIL wrap_count: writes=%0d, need 2", wr_addr_q.size());
    end else begin
      vectors++;
      if (wr_addr_q[0] !== 24'hFFFFFE || wr_addr_q[1] !== 24'h000000 ||
          wr_data_q[0] !== 16'h5A5A || wr_data_q[1] !== 16'h5A5A) begin
        miscompares++;
        $display("FAIL wrap_addr: %h/%h data %h/%h, need FFFFFE/000000 5A5A/5A5A",
                 wr_addr_q[0], wr_addr_q[1], wr_data_q[0], wr_data_q[1]);
      end
    end
    irq_clear("wrap");
  endtask

`ifdef CD_DMA_CHECKSUM_EN
  task automatic test_checksum();
    int cyc;
    clear_log();
    program_regs(24'h000000, 24'h300000, 32'd3, 16'h8000);
    reg_write(3'd0, 16'h0003);
    wait_done(200, "csum", cyc);
    repeat (2) @(negedge clk);
    vectors++;
    if (checksum !== 16'h8000 || bus.STATUS[4] !== 1'b1) begin
      miscompares++;
      $display("FAIL checksum: sum=%h flag=%b, need 8000 1", checksum, bus.STATUS[4]);
    end
    irq_clear("csum");
  endtask
`endif

  task automatic test_reset_mid();
    int n = 0;
    clear_log();
    program_regs(24'h100000, 24'h200000, 32'd10, 16'h0000);
    reg_write(3'd0, 16'h0001);
    while (!(bus.nBGACK === 1'b0 && bus.MEM_REQ === 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.nBGACK !== 1'b0 || bus.MEM_REQ !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_owned: nBGACK=%b REQ=%b, need 0 1", bus.nBGACK, bus.MEM_REQ);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.nBR, bus.nBGACK, bus.MEM_REQ} !== 3'b110 || bus.STATUS !== STATUS_RST) begin
      miscompares++;
      $display("FAIL rstmid_release: nBR,nBGACK,REQ=%b STATUS=%h, need 110 %h",
               {bus.nBR, bus.nBGACK, bus.MEM_REQ}, bus.STATUS, STATUS_RST);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    grant_en      = 1'b1;
    bus.REG_WR    = 1'b0;
    bus.REG_SEL   = 3'd0;
    bus.REG_WDATA = 16'h0000;
    rst           = 1'b1;
    test_reset();
    test_copy();
    test_fill();
    test_zero_count();
    test_abort();
    test_abort_busreq();
    test_abort_last_word();
    test_wrap();
`ifdef CD_DMA_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
